// File: rtl/buzzer_melody_sequencer.sv
// buzzer_melody_sequencer: plays a fixed 8-note melody on a passive buzzer on each btn1 press
//
// Ports:
//   clk    in   system clock (27 MHz nominal)
//   rst_n  in   asynchronous active-low reset
//   btn1   in   push button, active low, asynchronous to clk
//   buzz   out  square wave to the buzzer pin, 0 when silent
//   busy   out  1 while a note or inter-note gap is in progress
//   led    out  active low: [2:0]=~note index, [3]=~PLAY, [4]=~GAP, [5]=synchronised btn1
module buzzer_melody_sequencer #(
    parameter int TICK_CYCLES = 27000,
    parameter int DEBOUNCE_MS = 10,
    parameter int GAP_MS      = 20,
    parameter int TONE_SHIFT  = 0,
    parameter bit LOOP        = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn1,
    output logic       buzz,
    output logic       busy,
    output logic [5:0] led
);
    localparam int PW = $clog2(TICK_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [15:0] ROM_HALF [8] = '{16'd25813, 16'd22998, 16'd20486, 16'd19341,
                                             16'd17219, 16'd15341, 16'd13664, 16'd12894};

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state;
    logic          sync1, sync2, deb, deb_q;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] pre, note_pre;
    logic [9:0]    note_ticks, note_len;
    logic [15:0]   tone, half;
    logic [2:0]    idx;
    logic          play_n, gap_n;
    logic          tick, note_tick, note_end, tone_wrap, press_evt;

    assign tick      = pre == PRE_MAX;
    assign note_tick = note_pre == PRE_MAX;
    assign half      = ROM_HALF[idx] >> TONE_SHIFT;
    // one timer serves both the note and the gap, so its limit follows the state
    assign note_len  = state == PLAY ? (idx == 3'd7 ? 10'd400 : 10'd200) : 10'(GAP_MS);
    assign note_end  = note_tick && note_ticks == note_len - 10'd1;
    assign tone_wrap = tone == half - 16'd1;
    assign press_evt = deb_q & ~deb;
    assign led       = {sync2, gap_n, play_n, ~idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_q   <= 1'b1;
            deb_cnt <= '0;
            pre     <= '0;
        end else begin
            sync1 <= btn1;
            sync2 <= sync1;
            deb_q <= deb;
            pre   <= tick ? '0 : pre + PW'(1);
            // the level must disagree across DEBOUNCE_MS whole tick intervals, so the
            // flip happens on the tick after the count has reached DEBOUNCE_MS
            if (sync2 == deb)
                deb_cnt <= '0;
            else if (tick) begin
                if (deb_cnt == DW'(DEBOUNCE_MS)) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else
                    deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            tone       <= '0;
            buzz       <= 1'b0;
            busy       <= 1'b0;
            play_n     <= 1'b1;
            gap_n      <= 1'b1;
            note_pre   <= '0;
            note_ticks <= '0;
        end else begin
            // silence and a cleared tone counter unless PLAY keeps the wave running
            buzz       <= 1'b0;
            tone       <= '0;
            note_pre   <= note_tick ? '0 : note_pre + PW'(1);
            note_ticks <= note_ticks + (note_tick ? 10'd1 : 10'd0);
            if (press_evt && state != IDLE) begin
                state  <= IDLE;
                idx    <= '0;
                busy   <= 1'b0;
                play_n <= 1'b1;
                gap_n  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        note_pre   <= '0;
                        note_ticks <= '0;
                        if (press_evt) begin
                            state  <= PLAY;
                            idx    <= '0;
                            busy   <= 1'b1;
                            play_n <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (note_end) begin
                            state      <= GAP;
                            note_pre   <= '0;
                            note_ticks <= '0;
                            play_n     <= 1'b1;
                            gap_n      <= 1'b0;
                        end else if (half != 16'd0) begin
                            tone <= tone_wrap ? '0 : tone + 16'd1;
                            buzz <= tone_wrap ? ~buzz : buzz;
                        end
                    end
                    GAP: begin
                        if (note_end) begin
                            note_pre   <= '0;
                            note_ticks <= '0;
                            gap_n      <= 1'b1;
                            if (idx == 3'd7 && !LOOP) begin
                                state <= IDLE;
                                idx   <= '0;
                                busy  <= 1'b0;
                            end else begin
                                // 3-bit index wraps 7 -> 0 for the looping case
                                state  <= PLAY;
                                idx    <= idx + 3'd1;
                                play_n <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_buzzer_melody_sequencer.sv
// tb_buzzer_melody_sequencer: directed self-checking bench for buzzer_melody_sequencer
module tb_buzzer_melody_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0, btn_a = 1'b1, btn_f = 1'b1;
    logic       buzz_a, busy_a, buzz_b, busy_b, buzz_c, busy_c;
    logic [5:0] led_a, led_b, led_c;
    int         checks = 0, failures = 0, n, bad;

    always #5 clk = ~clk;

    buzzer_melody_sequencer #(.TICK_CYCLES(100), .DEBOUNCE_MS(2), .GAP_MS(20), .TONE_SHIFT(8), .LOOP(1'b0))
        dut_a (.clk(clk), .rst_n(rst_n), .btn1(btn_a), .buzz(buzz_a), .busy(busy_a), .led(led_a));
    buzzer_melody_sequencer #(.TICK_CYCLES(10), .DEBOUNCE_MS(2), .GAP_MS(20), .TONE_SHIFT(8), .LOOP(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .btn1(btn_f), .buzz(buzz_b), .busy(busy_b), .led(led_b));
    buzzer_melody_sequencer #(.TICK_CYCLES(10), .DEBOUNCE_MS(2), .GAP_MS(20), .TONE_SHIFT(8), .LOOP(1'b1))
        dut_c (.clk(clk), .rst_n(rst_n), .btn1(btn_f), .buzz(buzz_c), .busy(busy_c), .led(led_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return busy_a;
            1: return buzz_a;
            2: return led_a[3];
            3: return busy_b;
            4: return buzz_b;
            5: return led_b[3];
            default: return buzz_c;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w, input logic v, input int bound, output int cnt);
        cnt = 0;
        while (sig(w) !== v && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_reached"}, sig(w), v);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_buzz_a", buzz_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_led_a", led_a, 6'h3f);
        chk("rst_led_b", led_b, 6'h3f);
        rst_n = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (buzz_a || busy_a || led_a != 6'h3f) bad++;
        end
        chk("idle_10000", bad, 0);

        btn_a = 1'b0;
        bad = 0;
        repeat (150) begin
            @(negedge clk);
            if (buzz_a || busy_a) bad++;
        end
        btn_a = 1'b1;
        repeat (850) begin
            @(negedge clk);
            if (buzz_a || busy_a) bad++;
        end
        chk("glitch_quiet", bad, 0);
        chk("glitch_led", led_a, 6'h3f);

        btn_f = 1'b0;
        wait_for("f_press", 3, 1'b1, 100, n);
        chk("f_press_lat", n >= 20 && n <= 40, 1);
        chk("f_led_n0", led_b, 6'b010111);
        btn_f = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_for("f_gap", 5, 1'b1, 2100, n);
            chk("f_play_len", n, 2000);
            wait_for("f_note", 5, 1'b0, 300, n);
            chk("f_gap_len", n, 200);
        end
        chk("f_led_n3", led_b, 6'b110100);
        btn_f = 1'b0;
        wait_for("f_abort", 3, 1'b0, 100, n);
        chk("f_abort_lat", n >= 20 && n <= 40, 1);
        chk("f_abort_led", led_b, 6'b011111);
        chk("f_abort_buzz", buzz_b, 0);
        chk("f_abort_busy_c", busy_c, 0);
        btn_f = 1'b1;
        repeat (100) @(negedge clk);
        chk("f_release_idle", busy_b, 0);
        btn_f = 1'b0;
        wait_for("f_restart", 3, 1'b1, 100, n);
        chk("f_restart_led", led_b, 6'b010111);
        btn_f = 1'b1;
        wait_for("f_melody", 3, 1'b0, 21000, n);
        chk("f_melody_len", n, 19600);
        chk("f_end_led", led_b, 6'h3f);
        chk("loop_busy", busy_c, 1);
        chk("loop_led", led_c, 6'b110111);
        wait_for("loop_buzz", 6, 1'b1, 300, n);
        chk("loop_half", n, 100);

        btn_a = 1'b0;
        wait_for("a_press", 0, 1'b1, 400, n);
        chk("a_press_lat", n >= 200 && n <= 310, 1);
        chk("a_led_n0", led_a, 6'b010111);
        chk("a_entry_buzz", buzz_a, 0);
        wait_for("a_rise1", 1, 1'b1, 300, n);
        chk("a_half1", n, 100);
        wait_for("a_fall1", 1, 1'b0, 300, n);
        chk("a_half2", n, 100);
        wait_for("a_rise2", 1, 1'b1, 300, n);
        chk("a_half3", n, 100);
        wait_for("a_gap", 2, 1'b1, 20000, n);
        chk("a_play_len", n, 19700);
        chk("a_gap_led", led_a, 6'b001111);
        chk("a_gap_buzz", buzz_a, 0);
        wait_for("a_note1", 2, 1'b0, 2100, n);
        chk("a_gap_len", n, 2000);
        chk("a_led_n1", led_a, 6'b010110);
        wait_for("a_n1_rise", 1, 1'b1, 200, n);
        chk("a_n1_half", n, 89);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_buzz", buzz_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_led", led_a, 6'h3f);
        chk("arst_busy_c", busy_c, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
